pipe_rca_adder: RTL and testbench

PIPE_RCA_ADDER -- requirements
Module: pipe_rca_adder

---
 rtl/pipe_rca_adder_pkg.sv | 12 +
 rtl/pipe_rca_adder_rca_chunk.sv | 29 ++
 rtl/pipe_rca_adder.sv | 130 +++++++++++++
 tb/tb_pipe_rca_adder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_rca_adder_pkg.sv
// Shared constants and mode encoding for the pipelined ripple-carry adder.
package pipe_rca_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/pipe_rca_adder_rca_chunk.sv
// Combinational ripple-carry slice; cm is the carry into the top bit,
// so cm ^ co gives signed overflow when this slice holds the sign bit.
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cm
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[W];
    assign cm = c[W-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, with
// skewed operand/sum registers and a global stall from the output side.
module pipe_rca_adder
    import pipe_rca_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SDIV  = (STAGES > 0) ? STAGES : 1;
    localparam int CHUNK = WIDTH / SDIV;

    if (STAGES < 1 || (WIDTH % SDIV) != 0) begin : g_cfg_err
        $error("pipe_rca_adder: WIDTH must be a multiple of STAGES >= 1");
    end

    mode_e mode;
    logic  inv;
    logic  stall;

    assign mode     = mode_e'(sub);
    assign inv      = (mode == MODE_SUB);
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CHUNK;
        localparam int RW = WIDTH - LO;

        logic               v_i;
        logic               c_i;
        logic [RW-1:0]      a_i;
        logic [RW-1:0]      b_i;
        logic [CHUNK-1:0]   s_c;
        logic [LO+CHUNK-1:0] s_n;
        logic               co;
        logic               cm;
        logic               v_q;
        logic               c_q;
        logic [LO+CHUNK-1:0] s_q;

        if (k == 0) begin : g_in
            // Subtract is a + ~b + ~borrow; inversion happens on entry.
            assign v_i = in_valid;
            assign c_i = cin ^ inv;
            assign a_i = a;
            assign b_i = b ^ {WIDTH{inv}};
            assign s_n = s_c;
        end else begin : g_in
            assign v_i = g_st[k-1].v_q;
            assign c_i = g_st[k-1].c_q;
            assign a_i = g_st[k-1].g_sk.a_q;
            assign b_i = g_st[k-1].g_sk.b_q;
            assign s_n = {s_c, g_st[k-1].s_q};
        end

        rca_chunk #(
            .W (CHUNK)
        ) u_rca (
            .a  (a_i[CHUNK-1:0]),
            .b  (b_i[CHUNK-1:0]),
            .ci (c_i),
            .s  (s_c),
            .co (co),
            .cm (cm)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (!stall) begin
                v_q <= v_i;
                if (v_i) begin
                    c_q <= co;
                    s_q <= s_n;
                end
            end
        end

        if (k < STAGES - 1) begin : g_sk
            logic [RW-CHUNK-1:0] a_q;
            logic [RW-CHUNK-1:0] b_q;
            logic                unused_cm;

            assign unused_cm = cm;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall && v_i) begin
                    a_q <= a_i[RW-1:CHUNK];
                    b_q <= b_i[RW-1:CHUNK];
                end
            end
        end else begin : g_ov
            logic o_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_q <= 1'b0;
                end else if (!stall && v_i) begin
                    o_q <= cm ^ co;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].s_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_ov.o_q;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Bench for pipe_rca_adder: directed corner cases plus a randomized
// stream checked against an integer-arithmetic reference model.
module tb_pipe_rca_adder;

    localparam int W = 16;
    localparam int S = 4;

    typedef logic [W+1:0] res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t exp_q[$];
    res_t obs_q[$];
    int   exp_t[$];
    int   obs_t[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_rca_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: plain integer add/subtract, overflow from signed range.
    function automatic res_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic c,
                                   input logic s);
        int ux, uy, uc, sx, sy, ru, rs;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        uc = int'(c);
        sx = int'(signed'(x));
        sy = int'(signed'(y));
        if (s) begin
            ru = ux - uy - uc;
            co = (ux >= uy + uc);
            rs = sx - sy - uc;
        end else begin
            ru = ux + uy + uc;
            co = (ru >= (1 << W));
            rs = sx + sy + uc;
        end
        ov = (rs > (1 << (W - 1)) - 1) || (rs < -(1 << (W - 1)));
        return {ru[W-1:0], co, ov};
    endfunction

    task automatic tick();
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            exp_t.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            obs_q.push_back({sum, cout, ovf});
            obs_t.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        exp_t.delete();
        obs_t.delete();
    endtask

    task automatic rand_op();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("FAIL rst_sum got %h want 0000", sum);
        end
        checks++;
        if (cout !== 1'b0) begin
            errors++;
            $display("FAIL rst_cout got %b want 0", cout);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_ovf got %b want 0", ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        clear_q();
        out_ready = 1'b1;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL add_count got %0d want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {16'h0000, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL add_result got %h want %h",
                         obs_q[0], {16'h0000, 1'b1, 1'b0});
            end
            checks++;
            if (obs_t[0] - exp_t[0] != S) begin
                errors++;
                $display("FAIL add_latency got %0d want %0d",
                         obs_t[0] - exp_t[0], S);
            end
        end
    endtask

    task automatic test_sub();
        clear_q();
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'h8000; b = 16'h0001; cin = 1'b0; sub = 1'b1;
        tick();
        a = 16'h0003; b = 16'h0005; cin = 1'b0; sub = 1'b1;
        tick();
        in_valid = 1'b0;
        sub = 1'b0;
        repeat (8) tick();
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL sub_count got %0d want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {16'h7FFF, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL sub_ovf_case got %h want %h",
                         obs_q[0], {16'h7FFF, 1'b1, 1'b1});
            end
            checks++;
            if (obs_q[1] !== {16'hFFFE, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL sub_borrow_case got %h want %h",
                         obs_q[1], {16'hFFFE, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_op();
            sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (obs_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_t[i] != exp_t[0] + S + i) begin
                    errors++;
                    $display("FAIL b2b_cycle[%0d] got %0d want %0d",
                             i, obs_t[i], exp_t[0] + S + i);
                end
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W+2:0] snap;
        clear_q();
        snap = '0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            rand_op();
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            rand_op();
            out_ready = 1'b0;
            #1;
            if (j == 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_pending got %b want 1", out_valid);
                end
                snap = {out_valid, sum, cout, ovf};
            end else begin
                checks++;
                if ({out_valid, sum, cout, ovf} !== snap) begin
                    errors++;
                    $display("FAIL bp_hold[%0d] got %h want %h",
                             j, {out_valid, sum, cout, ovf}, snap);
                end
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d] got %b want 0", j, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (12) tick();
        checks++;
        if (obs_q.size() != 5 || exp_q.size() != 5) begin
            errors++;
            $display("FAIL bp_count got %0d/%0d want 5/5",
                     obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_result[%0d] got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            rand_op();
            tick();
        end
        in_valid = 1'b0;
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending got %b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, sum, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset_out got %h want 0",
                     {out_valid, sum, cout, ovf});
        end
        clear_q();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL mid_stale got %0d results want 0", obs_q.size());
        end
        clear_q();
        rand_op();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL mid_next_count got %0d want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL mid_next_result got %h want %h",
                         obs_q[0], exp_q[0]);
            end
            checks++;
            if (obs_t[0] - exp_t[0] != S) begin
                errors++;
                $display("FAIL mid_next_latency got %0d want %0d",
                         obs_t[0] - exp_t[0], S);
            end
        end
    endtask

    task automatic test_random();
        logic         prev_stall;
        logic [W+2:0] prev;
        int           guard;
        int           n;
        clear_q();
        prev_stall = 1'b0;
        prev = '0;
        guard = 0;
        while (exp_q.size() < 10000 && guard < 40000) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            rand_op();
            #1;
            if (prev_stall) begin
                checks++;
                if ({out_valid, sum, cout, ovf} !== prev) begin
                    errors++;
                    $display("FAIL rnd_hold cyc %0d got %h want %h",
                             cyc, {out_valid, sum, cout, ovf}, prev);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_valid, sum, cout, ovf};
            tick();
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (S + 4) tick();
        checks++;
        if (guard >= 40000 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_count got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_result[%0d] got %h want %h",
                         i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
